// File: rtl/fpc_pkg.sv
// FloPoCo exception codes, field positions and the FloPoCo-to-IEEE-754 conversion.
package fpc_pkg;

    typedef enum logic [1:0] {
        EXN_ZERO   = 2'b00,
        EXN_NORMAL = 2'b01,
        EXN_INF    = 2'b10,
        EXN_NAN    = 2'b11
    } fpc_exn_e;

    localparam int unsigned FPC_W    = 34;
    localparam int unsigned IEEE_W   = 32;
    localparam int unsigned EXN_HI   = 33;
    localparam int unsigned EXN_LO   = 32;
    localparam int unsigned SIGN_BIT = 31;
    localparam int unsigned EXP_HI   = 30;
    localparam int unsigned EXP_LO   = 23;

    localparam logic [IEEE_W-1:0] QNAN32 = 32'h7FC00000;

    function automatic logic [IEEE_W-1:0] fpc_to_ieee(input logic [FPC_W-1:0] w);
        logic [IEEE_W-1:0] r;
        logic              s;
        fpc_exn_e          e;
        s = w[SIGN_BIT];
        e = fpc_exn_e'(w[EXN_HI:EXN_LO]);
        case (e)
            // A zero exponent would read as a denormal in IEEE, so flush to signed zero.
            EXN_NORMAL: r = (w[EXP_HI:EXP_LO] != 8'h00) ? w[IEEE_W-1:0] : {s, 31'h0};
            EXN_INF:    r = {s, 8'hFF, 23'h0};
            EXN_NAN:    r = QNAN32;
            default:    r = {s, 31'h0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/stream_fifo_fwft.sv
// First-word-fall-through FIFO: head word is visible on o_rdata whenever o_valid is high.
module stream_fifo_fwft #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    // Storage needs no reset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/coriolis_fpc2ieee_sink.sv
// Result-stream sink: converts FloPoCo words to IEEE-754 single and buffers them in a FWFT FIFO,
// with early upstream ready, sticky overflow and saturating NaN/Inf counters.
module coriolis_fpc2ieee_sink
    import fpc_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned SLACK = 13,
    parameter int unsigned CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ivalid,
    input  logic [33:0]     in1,
    output logic            iready,
    output logic            ovalid,
    output logic [31:0]     out1,
    input  logic            oready,
    output logic            ovf,
    output logic [CNTW-1:0] nan_cnt,
    output logic [CNTW-1:0] inf_cnt
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            w_valid;
    logic [31:0]     w_rdata;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_count_next;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    fpc_exn_e        w_exn;

    logic            r_iready;
    logic            r_ovf;
    logic [CNTW-1:0] r_nan_cnt;
    logic [CNTW-1:0] r_inf_cnt;

    assign w_pop        = w_valid & oready;
    assign w_full       = (w_count == CW'(DEPTH));
    // iready is only advisory: anything that fits is taken.
    assign w_push       = ivalid & (~w_full | w_pop);
    assign w_exn        = fpc_exn_e'(in1[EXN_HI:EXN_LO]);
    assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);

    stream_fifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (fpc_to_ieee(in1)),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_valid (w_valid),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iready  <= 1'b0;
            r_ovf     <= 1'b0;
            r_nan_cnt <= '0;
            r_inf_cnt <= '0;
        end else begin
            // Drop ready while SLACK words can still land after the kernel sees it.
            r_iready <= (CW'(DEPTH) - w_count_next) > CW'(SLACK);
            if (ivalid && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
            if (w_push && (w_exn == EXN_NAN) && (r_nan_cnt != '1)) begin
                r_nan_cnt <= r_nan_cnt + CNTW'(1);
            end
            if (w_push && (w_exn == EXN_INF) && (r_inf_cnt != '1)) begin
                r_inf_cnt <= r_inf_cnt + CNTW'(1);
            end
        end
    end

    assign iready  = r_iready;
    assign ovalid  = w_valid;
    assign out1    = w_valid ? w_rdata : 32'h0;
    assign ovf     = r_ovf;
    assign nan_cnt = r_nan_cnt;
    assign inf_cnt = r_inf_cnt;

endmodule

// File: tb/tb_coriolis_fpc2ieee_sink.sv
// Scoreboard bench: accepted words push expected IEEE values; a negedge monitor pops and compares.
module tb_coriolis_fpc2ieee_sink;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned SLACK = 13;
    localparam int unsigned CNTW  = 4;
    localparam int          CMAX  = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ivalid = 1'b0;
    logic [33:0]     in1 = '0;
    logic            oready = 1'b0;
    logic            iready;
    logic            ovalid;
    logic [31:0]     out1;
    logic            ovf;
    logic [CNTW-1:0] nan_cnt;
    logic [CNTW-1:0] inf_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic        exp_iready = 1'b0;
    logic        exp_ovf = 1'b0;
    int          exp_nan = 0;
    int          exp_inf = 0;
    bit          after_rst = 1'b0;

    coriolis_fpc2ieee_sink #(
        .DEPTH (DEPTH),
        .SLACK (SLACK),
        .CNTW  (CNTW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ivalid  (ivalid),
        .in1     (in1),
        .iready  (iready),
        .ovalid  (ovalid),
        .out1    (out1),
        .oready  (oready),
        .ovf     (ovf),
        .nan_cnt (nan_cnt),
        .inf_cnt (inf_cnt)
    );

    always #5 clk = ~clk;

    // Reference conversion from the format rules.
    function automatic logic [31:0] ref_conv(input logic [33:0] w);
        logic [1:0] e;
        logic       s;
        e = w[33:32];
        s = w[31];
        if (e == 2'b11) return 32'h7FC00000;
        if (e == 2'b10) return {s, 8'hFF, 23'h0};
        if (e == 2'b01 && w[30:23] != 8'h00) return w[31:0];
        return {s, 31'h0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of acceptance: a word is taken if the queue (already popped this cycle) has room.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_iready = 1'b0;
            exp_ovf    = 1'b0;
            exp_nan    = 0;
            exp_inf    = 0;
            after_rst  = 1'b1;
        end else begin
            after_rst = 1'b0;
            if (ivalid) begin
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back(ref_conv(in1));
                    if (in1[33:32] == 2'b11 && exp_nan < CMAX) exp_nan++;
                    if (in1[33:32] == 2'b10 && exp_inf < CMAX) exp_inf++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            exp_iready = (DEPTH - exp_q.size()) > SLACK;
        end
    end

    always @(negedge clk) begin
        check("ovalid", 32'(ovalid), 32'(exp_q.size() != 0));
        check("iready", 32'(iready), 32'(exp_iready));
        check("ovf", 32'(ovf), 32'(exp_ovf));
        check("nan_cnt", 32'(nan_cnt), exp_nan);
        check("inf_cnt", 32'(inf_cnt), exp_inf);
        if (after_rst) check("out1_rst", out1, 32'h0);
        if (ovalid && oready && exp_q.size() != 0) begin
            check("out1", out1, exp_q[0]);
            void'(exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [33:0] w);
        ivalid = 1'b1;
        in1    = w;
        tick();
    endtask

    task automatic idle(input int n);
        ivalid = 1'b0;
        repeat (n) tick();
    endtask

    logic [33:0] sweep [5];

    initial begin
        logic [31:0] r0;
        logic [31:0] r1;
        sweep[0] = 34'h1_3F800000;
        sweep[1] = 34'h2_80000000;
        sweep[2] = 34'h3_12345678;
        sweep[3] = 34'h0_80000000;
        sweep[4] = 34'h1_00400000;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        idle(2);

        // Conversion sweep
        oready = 1'b1;
        for (int i = 0; i < 5; i++) send(sweep[i]);
        idle(3);

        // Backpressure: fill to DEPTH then drain
        oready = 1'b0;
        for (int i = 0; i < 16; i++) send({2'b01, 32'(32'h3F800000 + i)});
        idle(2);
        oready = 1'b1;
        idle(20);

        // Overflow: 17 words into a stalled FIFO
        oready = 1'b0;
        for (int i = 0; i < 17; i++) send({2'b01, 32'(32'h40000000 + i)});
        idle(3);
        oready = 1'b1;
        idle(20);

        // Full with simultaneous push and pop
        oready = 1'b0;
        for (int i = 0; i < 16; i++) send({2'b01, 32'(32'h41000000 + i)});
        oready = 1'b1;
        for (int i = 0; i < 20; i++) send({2'b01, 32'(32'h42000000 + i)});
        idle(20);

        // Counter saturation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        oready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            r0 = $urandom();
            send({2'b11, r0});
        end
        idle(2);
        check("nan_sat", 32'(nan_cnt), 32'hF);
        check("inf_zero", 32'(inf_cnt), 32'h0);
        for (int i = 0; i < 3; i++) begin
            r0 = $urandom();
            send({2'b10, r0});
        end
        idle(2);
        check("inf_three", 32'(inf_cnt), 32'h3);

        // Reset mid-stream with 5 words buffered
        oready = 1'b0;
        for (int i = 0; i < 5; i++) send({2'b01, 32'(32'h43000000 + i)});
        ivalid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(3);
        oready = 1'b1;
        idle(5);

        // Randomized traffic with bursts of backpressure
        for (int i = 0; i < 1000; i++) begin
            r0 = $urandom();
            r1 = $urandom();
            ivalid = (r0[3:0] < 4'd11);
            in1    = {r0[9:8], r1};
            if ((i / 64) % 2 == 1) oready = (r0[7:5] == 3'd0);
            else                   oready = (r0[7:5] < 3'd6);
            tick();
        end

        oready = 1'b1;
        idle(25);
        check("drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
